// File: rtl/cluster_unpacker.sv
// Rebuilds the per-frame vpf bitmap from a serial stream of cluster addresses.
// Optional CLUSTER_SIZE_EN adds cluster_size so each cluster covers adr..adr+size.
module cluster_unpacker #(
    parameter int MXVPF      = 768,
    parameter int MXADRB     = 10,
    parameter int MXCLUSTERS = 8,
    parameter int MXCNTB     = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              latch_pulse,
    input  logic              cluster_vld,
    input  logic [MXADRB-1:0] cluster_adr,
`ifdef CLUSTER_SIZE_EN
    input  logic [2:0]        cluster_size,
`endif
    output logic [MXVPF-1:0]  vpfs_out,
    output logic              vpfs_valid,
    output logic [MXCNTB-1:0] cluster_count,
    output logic              overflow,
    output logic              adr_err
);

    localparam logic [MXADRB+1:0] VPF_LIM = (MXADRB+2)'(MXVPF);
    localparam logic [MXCNTB-1:0] CNT_MAX = MXCNTB'(MXCLUSTERS);

    logic [MXVPF-1:0]  acc;
    logic [MXVPF-1:0]  acc_base;
    logic [MXVPF-1:0]  acc_nxt;
    logic [MXVPF-1:0]  mask;
    logic [MXCNTB-1:0] cnt;
    logic [MXCNTB-1:0] cnt_base;
    logic [MXCNTB-1:0] cnt_nxt;
    logic              ovf_s;
    logic              ovf_nxt;
    logic              err_s;
    logic              err_nxt;
    logic [MXADRB+1:0] lo;
    logic [MXADRB+1:0] hi;
    logic              in_range;

    // Span mask; two guard bits keep adr+size from wrapping.
    always_comb begin
        lo = {2'b00, cluster_adr};
`ifdef CLUSTER_SIZE_EN
        hi = lo + {{(MXADRB-1){1'b0}}, cluster_size};
`else
        hi = lo;
`endif
        in_range = (lo < VPF_LIM);
        mask     = '0;
        for (int i = 0; i < MXVPF; i++) begin
            mask[i] = ((MXADRB+2)'(i) >= lo) && ((MXADRB+2)'(i) <= hi);
        end
    end

    // A cluster arriving with latch_pulse lands in the freshly cleared frame.
    always_comb begin
        acc_base = latch_pulse ? '0 : acc;
        cnt_base = latch_pulse ? '0 : cnt;
        acc_nxt  = acc_base;
        cnt_nxt  = cnt_base;
        ovf_nxt  = latch_pulse ? 1'b0 : ovf_s;
        err_nxt  = latch_pulse ? 1'b0 : err_s;
        if (cluster_vld) begin
            if (!in_range) begin
                err_nxt = 1'b1;
            end else if (cnt_base == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                acc_nxt = acc_base | mask;
                cnt_nxt = cnt_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc   <= '0;
            cnt   <= '0;
            ovf_s <= 1'b0;
            err_s <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf_s <= ovf_nxt;
            err_s <= err_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vpfs_out      <= '0;
            vpfs_valid    <= 1'b0;
            cluster_count <= '0;
            overflow      <= 1'b0;
            adr_err       <= 1'b0;
        end else begin
            vpfs_valid <= latch_pulse;
            if (latch_pulse) begin
                vpfs_out      <= acc;
                cluster_count <= cnt;
                overflow      <= ovf_s;
                adr_err       <= err_s;
            end
        end
    end

endmodule
